kim_ifetch_p: RTL and testbench

Instruction fetch stage that drives the PC interface from the other side. It owns the next-PC sequencing, issues instruction-memory requests over a valid/ready handshake, and buffers returned instructions with their PCs. It presents them to the IF/ID pipeline register under ID-stage backpressure, and handles branch/jump redirects by flushing and discarding in-flight responses.

---
 rtl/kim_ifetch_p.sv | 214 +++++++++++++++++++++
 tb/tb_kim_ifetch_p.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kim_ifetch_p.sv
// Instruction fetch stage: next-PC sequencing, in-order imem request/response buffering,
// IF/ID presentation under ID stall, and redirect flushing. Optional: KIM_IFETCH_MISALIGN_TRAP_EN.
module kim_ifetch_p #(
    parameter int                       PC_ADDR_WIDTH = 32,
    parameter int                       INSTR_WIDTH   = 32,
    parameter logic [PC_ADDR_WIDTH-1:0] RESET_PC      = '0,
    parameter int                       BUF_DEPTH     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect_valid,
    input  logic [PC_ADDR_WIDTH-1:0] redirect_pc,
    input  logic                     id_stall,
    output logic                     imem_req_valid,
    output logic [PC_ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                     imem_req_ready,
    input  logic                     imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0]   imem_rsp_data,
    output logic                     if_valid,
    output logic [INSTR_WIDTH-1:0]   if_instr,
    output logic [PC_ADDR_WIDTH-1:0] if_pc,
    output logic                     if_exc
);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
`ifdef KIM_IFETCH_MISALIGN_TRAP_EN
        ST_TRAP  = 2'd2,
`endif
        ST_FLUSH = 2'd1
    } state_t;

    state_t state_reg, state_next;
    logic [PC_ADDR_WIDTH-1:0] pc_reg, pc_next;
    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] fill_reg, fill_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    // alloc counts entries issued and not yet popped; out counts those still awaiting data
    logic [CNT_W-1:0] alloc_cnt_reg, alloc_cnt_next;
    logic [CNT_W-1:0] out_cnt_reg, out_cnt_next;
    logic [CNT_W-1:0] drop_cnt_reg, drop_cnt_next;
    logic [CNT_W-1:0] drop_base;

    logic [PC_ADDR_WIDTH-1:0] pc_mem    [BUF_DEPTH];
    logic [INSTR_WIDTH-1:0]   instr_mem [BUF_DEPTH];

    logic issue;
    logic fill_en;
    logic buf_valid;
    logic trap_valid;
    logic pop;

`ifdef KIM_IFETCH_MISALIGN_TRAP_EN
    logic                     trap_pend_reg, trap_pend_next;
    logic                     trap_beat_reg, trap_beat_next;
    logic [PC_ADDR_WIDTH-1:0] trap_pc_reg, trap_pc_next;
    logic                     misaligned;

    assign misaligned = (redirect_pc[1:0] != 2'b00);
    assign trap_valid = (state_reg == ST_TRAP) && trap_beat_reg;
`else
    assign trap_valid = 1'b0;
`endif

    assign imem_req_valid = !rst && (state_reg == ST_FETCH) && !redirect_valid
                            && (alloc_cnt_reg < DEPTH_C);
    assign imem_req_addr  = rst ? '0 : pc_reg;
    assign issue          = imem_req_valid && imem_req_ready;
    assign fill_en        = !rst && imem_rsp_valid && (state_reg == ST_FETCH) && !redirect_valid;

    // Responses are in order, so the head is filled whenever any entry holds data
    assign buf_valid = (state_reg == ST_FETCH) && (alloc_cnt_reg != out_cnt_reg);
    assign if_valid  = !rst && !redirect_valid && (buf_valid || trap_valid);
    assign pop       = if_valid && !id_stall;

    always_comb begin
        if_pc    = '0;
        if_instr = '0;
        if_exc   = 1'b0;
        if (if_valid && buf_valid) begin
            if_pc    = pc_mem[head_reg];
            if_instr = instr_mem[head_reg];
        end
`ifdef KIM_IFETCH_MISALIGN_TRAP_EN
        if (if_valid && trap_valid) begin
            if_pc  = trap_pc_reg;
            if_exc = 1'b1;
        end
`endif
    end

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        head_next      = head_reg;
        fill_next      = fill_reg;
        tail_next      = tail_reg;
        alloc_cnt_next = alloc_cnt_reg;
        out_cnt_next   = out_cnt_reg;
        drop_cnt_next  = drop_cnt_reg;
`ifdef KIM_IFETCH_MISALIGN_TRAP_EN
        trap_pend_next = trap_pend_reg;
        trap_beat_next = trap_beat_reg;
        trap_pc_next   = trap_pc_reg;
`endif
        // Only one of drop/out is non-zero: FETCH has no drops, FLUSH/TRAP hold no live entries
        drop_base = drop_cnt_reg + out_cnt_reg;

        if (redirect_valid) begin
            pc_next        = redirect_pc & ~PC_ADDR_WIDTH'(3);
            head_next      = '0;
            fill_next      = '0;
            tail_next      = '0;
            alloc_cnt_next = '0;
            out_cnt_next   = '0;
            drop_cnt_next  = (imem_rsp_valid && drop_base != '0) ? drop_base - CNT_W'(1) : drop_base;
`ifdef KIM_IFETCH_MISALIGN_TRAP_EN
            trap_pend_next = misaligned;
            trap_beat_next = misaligned;
            trap_pc_next   = redirect_pc;
`endif
            if (drop_cnt_next != '0) begin
                state_next = ST_FLUSH;
            end
`ifdef KIM_IFETCH_MISALIGN_TRAP_EN
            else if (misaligned) begin
                state_next = ST_TRAP;
            end
`endif
            else begin
                state_next = ST_FETCH;
            end
        end else begin
            case (state_reg)
                ST_FETCH: begin
                    if (issue) begin
                        pc_next = pc_reg + PC_ADDR_WIDTH'(4);
                    end
                    tail_next      = tail_reg + PTR_W'(issue);
                    fill_next      = fill_reg + PTR_W'(fill_en);
                    head_next      = head_reg + PTR_W'(pop);
                    out_cnt_next   = out_cnt_reg + CNT_W'(issue) - CNT_W'(fill_en);
                    alloc_cnt_next = alloc_cnt_reg + CNT_W'(issue) - CNT_W'(pop);
                end
                ST_FLUSH: begin
                    if (imem_rsp_valid) begin
                        drop_cnt_next = drop_cnt_reg - CNT_W'(1);
                        if (drop_cnt_reg == CNT_W'(1)) begin
`ifdef KIM_IFETCH_MISALIGN_TRAP_EN
                            state_next = trap_pend_reg ? ST_TRAP : ST_FETCH;
`else
                            state_next = ST_FETCH;
`endif
                        end
                    end
                end
`ifdef KIM_IFETCH_MISALIGN_TRAP_EN
                ST_TRAP: begin
                    if (pop) begin
                        trap_beat_next = 1'b0;
                    end
                end
`endif
                default: state_next = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_FETCH;
            pc_reg        <= RESET_PC;
            head_reg      <= '0;
            fill_reg      <= '0;
            tail_reg      <= '0;
            alloc_cnt_reg <= '0;
            out_cnt_reg   <= '0;
            drop_cnt_reg  <= '0;
`ifdef KIM_IFETCH_MISALIGN_TRAP_EN
            trap_pend_reg <= 1'b0;
            trap_beat_reg <= 1'b0;
            trap_pc_reg   <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            head_reg      <= head_next;
            fill_reg      <= fill_next;
            tail_reg      <= tail_next;
            alloc_cnt_reg <= alloc_cnt_next;
            out_cnt_reg   <= out_cnt_next;
            drop_cnt_reg  <= drop_cnt_next;
`ifdef KIM_IFETCH_MISALIGN_TRAP_EN
            trap_pend_reg <= trap_pend_next;
            trap_beat_reg <= trap_beat_next;
            trap_pc_reg   <= trap_pc_next;
`endif
        end
    end

    // Entry storage needs no reset: validity is tracked entirely by the counters
    always_ff @(posedge clk) begin
        if (issue) begin
            pc_mem[tail_reg] <= pc_reg;
        end
        if (fill_en) begin
            instr_mem[fill_reg] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_kim_ifetch_p.sv
// Bench for kim_ifetch_p: queue-based fetch-stream model, in-order memory model with
// variable latency, directed scenarios with literal expectations, then randomized traffic.
module tb_kim_ifetch_p;
    localparam int DEPTH = 2;
`ifdef KIM_IFETCH_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_exc;

    kim_ifetch_p #(.PC_ADDR_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'h0), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_stall(id_stall),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_exc(if_exc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; bit filled; logic [31:0] data; } ent_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    ent_t        live[$];     // fetches since the last redirect, oldest first
    mreq_t       mem_q[$];    // requests accepted by the memory, oldest first
    int          drop_m;      // stale responses still to be swallowed
    logic [31:0] pc_m;
    bit          trap_pend_m, trap_beat_m;
    logic [31:0] trap_pc_m;
    int          cyc, last_due;
    logic [31:0] hs_log[$];
    logic [31:0] pop_log[$];
    bit          pop_exc_log[$];
    int          checks = 0, errors = 0;
    logic        s_ifv;
    logic [31:0] s_if_pc, s_req_addr;

    function automatic logic [31:0] hashf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_log(input string name, input bit use_pop, input int k, input logic [31:0] exp);
        int sz;
        sz = use_pop ? pop_log.size() : hs_log.size();
        if (sz > k) chk(name, use_pop ? pop_log[k] : hs_log[k], exp);
        else        chk({name, "_missing"}, sz, k + 1);
    endtask

    task automatic clear_logs();
        hs_log.delete();
        pop_log.delete();
        pop_exc_log.delete();
    endtask

    task automatic step(input bit r, input bit redir, input logic [31:0] rpc,
                        input bit stall, input bit ready, input int lat);
        bit rsp, in_trap, e_req, e_ifv, hs, pop, mis;
        int unf, due;
        @(negedge clk);
        rst            = r;
        redirect_valid = redir;
        redirect_pc    = rpc;
        id_stall       = stall;
        imem_req_ready = ready;
        rsp            = !r && mem_q.size() > 0 && mem_q[0].due <= cyc;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? hashf(mem_q[0].addr) : 32'h0;
        #1;
        s_ifv      = if_valid;
        s_if_pc    = if_pc;
        s_req_addr = imem_req_addr;
        if (r) begin
            chk("rst_req_valid", imem_req_valid, 0);
            chk("rst_if_valid", if_valid, 0);
            chk("rst_if_exc", if_exc, 0);
            chk("rst_if_pc", if_pc, 0);
            live.delete(); mem_q.delete();
            drop_m = 0; pc_m = 32'h0; trap_pend_m = 0; trap_beat_m = 0; trap_pc_m = 0; last_due = 0;
        end else begin
            in_trap = (drop_m == 0) && trap_pend_m;
            e_req   = (drop_m == 0) && !in_trap && !redir && (live.size() < DEPTH);
            chk("req_valid", imem_req_valid, e_req);
            if (e_req) chk("req_addr", imem_req_addr, pc_m);
            if (in_trap) e_ifv = trap_beat_m && !redir;
            else         e_ifv = (live.size() > 0) && live[0].filled && !redir;
            chk("if_valid", if_valid, e_ifv);
            if (e_ifv && in_trap) begin
                chk("trap_pc", if_pc, trap_pc_m);
                chk("trap_instr", if_instr, 0);
                chk("trap_exc", if_exc, 1);
            end else if (e_ifv) begin
                chk("if_pc", if_pc, live[0].pc);
                chk("if_instr", if_instr, live[0].data);
                chk("if_exc", if_exc, 0);
            end else begin
                chk("idle_exc", if_exc, 0);
            end
            hs  = imem_req_valid && ready;
            pop = e_ifv && !stall;
            if (hs) hs_log.push_back(imem_req_addr);
            if (pop) begin
                pop_log.push_back(if_pc);
                pop_exc_log.push_back(if_exc);
                $display("IF pc=%08h instr=%08h exc=%0d cycle=%0d", if_pc, if_instr, if_exc, cyc);
            end
            if (rsp) void'(mem_q.pop_front());
            if (hs) begin
                due = (cyc + lat > last_due) ? cyc + lat : last_due;
                last_due = due;
                mem_q.push_back('{addr: imem_req_addr, due: due});
            end
            if (redir) begin
                unf = 0;
                foreach (live[i]) if (!live[i].filled) unf++;
                drop_m = drop_m + unf - (rsp ? 1 : 0);
                live.delete();
                pc_m = rpc & ~32'h3;
                mis = TRAP_EN && (rpc[1:0] != 2'b00);
                trap_pend_m = mis; trap_beat_m = mis; trap_pc_m = rpc;
            end else begin
                if (rsp) begin
                    if (drop_m > 0) drop_m--;
                    else begin
                        for (int i = 0; i < live.size(); i++) begin
                            if (!live[i].filled) begin
                                live[i].filled = 1; live[i].data = imem_rsp_data;
                                break;
                            end
                        end
                    end
                end
                if (pop && in_trap) trap_beat_m = 0;
                else if (pop) void'(live.pop_front());
                if (e_req && ready) begin
                    live.push_back('{pc: pc_m, filled: 0, data: 32'h0});
                    pc_m = pc_m + 32'd4;
                end
            end
        end
        cyc++;
    endtask

    initial begin
        logic [31:0] held_pc;
        rst = 1; redirect_valid = 0; redirect_pc = 0; id_stall = 0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
        cyc = 0; drop_m = 0; pc_m = 0; last_due = 0;
        trap_pend_m = 0; trap_beat_m = 0; trap_pc_m = 0;
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 1);

        // Sequential fetch from reset, 1-cycle memory
        clear_logs();
        for (int i = 0; i < 14; i++) begin
            step(0, 0, 0, 0, 1, 1);
            if (i == 1) chk("first_beat_c1_idle", s_ifv, 0);
            if (i == 2) chk("first_beat_c2_valid", s_ifv, 1);
            if (i == 2) chk("first_beat_c2_pc", s_if_pc, 32'h0);
        end
        chk_log("seq_pc0", 1, 0, 32'h0);
        chk_log("seq_pc1", 1, 1, 32'h4);
        chk_log("seq_pc2", 1, 2, 32'h8);
        chk_log("seq_pc3", 1, 3, 32'hC);

        // ID stall for 5 cycles: output frozen, stream intact afterwards
        clear_logs();
        held_pc = 0;
        for (int j = 0; j < 5; j++) begin
            step(0, 0, 0, 1, 1, 1);
            if (j == 2) held_pc = s_if_pc;
            if (j > 2) chk("stall_hold_pc", s_if_pc, held_pc);
            if (j == 4) chk("stall_hold_valid", s_ifv, 1);
        end
        chk("stall_no_pop", pop_log.size(), 0);
        for (int j = 0; j < 10; j++) step(0, 0, 0, 0, 1, 1);
        chk_log("stall_release_pc", 1, 0, held_pc);
        for (int k = 0; k + 1 < pop_log.size(); k++)
            chk("stall_stride", pop_log[k + 1] - pop_log[k], 32'd4);

        // Memory not ready for 3 cycles at address 0x10
        clear_logs();
        step(0, 1, 32'h10, 0, 0, 1);
        for (int j = 0; j < 3; j++) begin
            step(0, 0, 0, 0, 0, 1);
            chk("notready_addr", s_req_addr, 32'h10);
        end
        for (int j = 0; j < 10; j++) step(0, 0, 0, 0, 1, 1);
        chk_log("notready_hs0", 0, 0, 32'h10);
        chk_log("notready_pop0", 1, 0, 32'h10);

        // Redirect with slow memory: stale responses discarded
        for (int j = 0; j < 6; j++) step(0, 0, 0, 0, 1, 3);
        step(0, 1, 32'h100, 0, 1, 3);
        clear_logs();
        for (int j = 0; j < 20; j++) step(0, 0, 0, 0, 1, 3);
        chk_log("redir_pop0", 1, 0, 32'h100);
        chk_log("redir_pop1", 1, 1, 32'h104);

        // PC wrap at the top of the address space
        for (int j = 0; j < 4; j++) step(0, 0, 0, 0, 1, 1);
        step(0, 1, 32'hFFFF_FFFC, 0, 1, 1);
        clear_logs();
        for (int j = 0; j < 10; j++) step(0, 0, 0, 0, 1, 1);
        chk_log("wrap_hs0", 0, 0, 32'hFFFF_FFFC);
        chk_log("wrap_hs1", 0, 1, 32'h0);
        chk_log("wrap_pop1", 1, 1, 32'h0);

        // Misaligned redirect
        step(0, 1, 32'h102, 0, 1, 1);
        clear_logs();
        for (int j = 0; j < 10; j++) step(0, 0, 0, 0, 1, 1);
`ifdef KIM_IFETCH_MISALIGN_TRAP_EN
        chk("mis_no_issue", hs_log.size(), 0);
        chk("mis_beats", pop_log.size(), 1);
        chk_log("mis_trap_pc", 1, 0, 32'h102);
        if (pop_exc_log.size() > 0) chk("mis_trap_exc", pop_exc_log[0], 1);
        else                        chk("mis_trap_exc_missing", pop_exc_log.size(), 1);
`else
        chk_log("mis_hs0", 0, 0, 32'h100);
        chk_log("mis_pop0", 1, 0, 32'h100);
`endif

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit r, rd, st, rdy;
            logic [31:0] rpc;
            int lat;
            r   = ($urandom_range(0, 499) == 0);
            rd  = ($urandom_range(0, 15) == 0);
            st  = ($urandom_range(0, 2) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            lat = $urandom_range(1, 4);
            case ($urandom_range(0, 7))
                0:       rpc = 32'hFFFF_FFF0 | ($urandom & 32'hC);
                1:       rpc = ($urandom & 32'h0000_0FFF) | 32'h1;
                default: rpc = $urandom & 32'h0000_0FFC;
            endcase
            step(r, rd, rpc, st, rdy, lat);
        end
        for (int j = 0; j < 12; j++) step(0, 0, 0, 0, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
